rect_scan: RTL
==============

# rect_scan

Sequencer and evaluator wrapped around the combinational `flip` stage in the rectangle-loop datapath. On `start` it latches a 4x4 binary matrix and drives that matrix plus one rectangle (r1<r2, c1<c2) per cycle into `flip`. It measures the Hamming weight of each flipped result and keeps the first rectangle that gives the minimum weight. When the sweep ends it reports that rectangle, its matrix and its weight.

## Interface
Parameters:
- ROWS, 4, matrix rows; fixed at 4 (coordinates are 2 bits)
- COLS, 4, matrix columns; fixed at 4

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a sweep; sampled only in IDLE
- m_in  in  16  matrix to search; bit index = 15-(c*ROWS+r)
- flip_m  out  16  latched matrix, to `flip.m_in`
- r1, r2, c1, c2  out  2 each  current rectangle, to `flip`
- flip_m_out  in  16  result from `flip.m_out`, same cycle (combinational)
- busy  out  1  high during SCAN
- done  out  1  one-cycle pulse when results are final
- best_m  out  16  best matrix found
- best_r1, best_r2, best_c1, best_c2  out  2 each  coordinates of the best rectangle
- best_weight  out  5  popcount of best_m (0..16)
- best_found  out  1  a rectangle strictly reduced the weight of the start matrix

## Operation
- States: IDLE, SCAN, DONE.
- IDLE, start=1:
  - latch m_in into flip_m
  - best_m <= m_in; best_weight <= popcount(m_in); best_found <= 0; best coordinates <= 0
  - go to SCAN
- IDLE, start=0: stay in IDLE.
- SCAN enumeration order (c2 varies fastest):
  - r1 0..2, then r2 r1+1..3, then c1 0..2, then c2 c1+1..3
  - 36 rectangles, one per cycle, starting with rectangle 0 = (0,1,0,1)
- SCAN evaluation, each cycle:
  - w = popcount(flip_m_out), 5-bit
  - if w < best_weight (strict), register flip_m_out, the current coordinates and w as best, and set best_found=1
  - ties keep the earlier rectangle
- SCAN exit: after rectangle 35 = (2,3,2,3) is evaluated, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- start is ignored in SCAN and DONE; there is no queueing.
- Outside SCAN, r1/r2/c1/c2 drive 0 and flip_m holds its value.
- best_* outputs hold until the next accepted start.
- Reset (async, any state): state=IDLE, and every output register goes to 0:
  - flip_m, coordinates, busy, done
  - best_m, best coordinates, best_weight, best_found
  - internal rectangle counter
- An aborted sweep produces no done pulse.

## Timing
- start sampled high in IDLE at edge T.
- SCAN occupies cycles T+1..T+36; rectangle k is on the coordinate outputs during cycle T+1+k.
- The best update for rectangle k is visible after edge T+2+k.
- DONE is cycle T+37: done=1, busy=0, best_* final.
- IDLE at T+38; the earliest next start is sampled at T+38.
- With start held high, sweeps run back-to-back every 38 cycles.
- busy=1 exactly in T+1..T+36; busy and done are never high together.
- flip_m is stable throughout SCAN; the `flip` path must close timing within one cycle.

## Test plan
- Reset: drive rst_n low with clk running, then mid-cycle → every output reads 0 immediately; state is IDLE.
- m_in=16'hFFFF:
  - cycle T+1 coordinates = 0,1,0,1
  - cycle T+7 coordinates = 0,2,0,1
  - done at T+37 with best_m=16'h33FF, best=(0,1,0,1), best_weight=12, best_found=1 (first tie wins)
- m_in=16'h0000: every rectangle gives weight 4 → best_found=0, best_m=16'h0000, best_weight=0, best coordinates 0,0,0,0, done at T+37.
- m_in=16'h0033: the last rectangle wins → best=(2,3,2,3), best_m=16'h0000, best_weight=0, best_found=1.
- start pulsed at T+5 and T+37 → both ignored. start held high from T → second sweep's SCAN begins T+39, done again at T+75.
- rst_n low during cycle T+10 → busy=0 at once, no done pulse. Release reset, then m_in=16'h0033 with start → correct result 37 cycles later.

Source files
------------

// File: rtl/rect_scan.sv
// Rectangle sweep sequencer around the combinational flip stage: enumerates every
// (r1<r2, c1<c2) rectangle of a latched 4x4 matrix and keeps the first minimum-weight result.
//
// state | meaning
// IDLE  | waiting for start; coordinates held at 0
// SCAN  | one rectangle per cycle into flip, best result tracked
// DONE  | one-cycle done pulse, best_* final
module rect_scan #(
    parameter int ROWS = 4,
    parameter int COLS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] m_in,
    output logic [15:0] flip_m,
    output logic [1:0]  r1,
    output logic [1:0]  r2,
    output logic [1:0]  c1,
    output logic [1:0]  c2,
    input  logic [15:0] flip_m_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] best_m,
    output logic [1:0]  best_r1,
    output logic [1:0]  best_r2,
    output logic [1:0]  best_c1,
    output logic [1:0]  best_c2,
    output logic [4:0]  best_weight,
    output logic        best_found
);

    localparam logic [1:0] RMAX = 2'(ROWS - 1);
    localparam logic [1:0] CMAX = 2'(COLS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t     state, state_nxt;
    logic       last_rect;
    logic [4:0] w;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
        return n;
    endfunction

    assign w         = popcount16(flip_m_out);
    assign last_rect = (r1 == RMAX - 2'd1) && (r2 == RMAX) &&
                       (c1 == CMAX - 2'd1) && (c2 == CMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last_rect) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flip_m      <= '0;
            r1          <= '0;
            r2          <= '0;
            c1          <= '0;
            c2          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            best_m      <= '0;
            best_r1     <= '0;
            best_r2     <= '0;
            best_c1     <= '0;
            best_c2     <= '0;
            best_weight <= '0;
            best_found  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        flip_m      <= m_in;
                        best_m      <= m_in;
                        best_weight <= popcount16(m_in);
                        best_found  <= 1'b0;
                        best_r1     <= '0;
                        best_r2     <= '0;
                        best_c1     <= '0;
                        best_c2     <= '0;
                        r1          <= 2'd0;
                        r2          <= 2'd1;
                        c1          <= 2'd0;
                        c2          <= 2'd1;
                        busy        <= 1'b1;
                    end
                end
                SCAN: begin
                    // Strict compare so that ties keep the earlier rectangle.
                    if (w < best_weight) begin
                        best_m      <= flip_m_out;
                        best_weight <= w;
                        best_r1     <= r1;
                        best_r2     <= r2;
                        best_c1     <= c1;
                        best_c2     <= c2;
                        best_found  <= 1'b1;
                    end
                    if (last_rect) begin
                        r1   <= '0;
                        r2   <= '0;
                        c1   <= '0;
                        c2   <= '0;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else if (c2 != CMAX) begin
                        c2 <= c2 + 2'd1;
                    end else if (c1 != CMAX - 2'd1) begin
                        c1 <= c1 + 2'd1;
                        c2 <= c1 + 2'd2;
                    end else if (r2 != RMAX) begin
                        r2 <= r2 + 2'd1;
                        c1 <= 2'd0;
                        c2 <= 2'd1;
                    end else begin
                        r1 <= r1 + 2'd1;
                        r2 <= r1 + 2'd2;
                        c1 <= 2'd0;
                        c2 <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
